// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline stall/flush sequencer with saturating event counters
module hazard_stall_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_rd,
    input  logic             imem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_Flush,
    output logic             ID_Bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BRLD  = 2'd1,
        FWAIT = 2'd2
    } state_t;

    state_t state;
    logic   brld_pend;

    logic mrs, mrt, dep;
    logic load_use, br_alu, br_load;
    logic stall;

    // r0 is hardwired zero, so it can never carry a real dependency
    always_comb begin
        mrs      = (EX_rd != 5'd0) && ID_uses_rs && (EX_rd == ID_rs);
        mrt      = (EX_rd != 5'd0) && ID_uses_rt && (EX_rd == ID_rt);
        dep      = mrs || mrt;
        load_use = EX_MemRead && dep;
        br_alu   = ID_Branch && EX_RegWrite && !EX_MemRead && dep;
        br_load  = ID_Branch && EX_MemRead && dep;
        stall    = (state == BRLD) || load_use || br_alu || br_load || !imem_ready;
    end

    // A stalled branch is re-evaluated later, so its taken flag is ignored here
    always_comb begin
        PC_Write    = !stall;
        IF_ID_Write = !stall;
        ID_Bubble   = stall;
        IF_Flush    = !stall && ID_BranchTaken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            brld_pend    <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!imem_ready) begin
                state <= FWAIT;
                // The BRLD cycle itself is consumed in place, only a new br_load is deferred
                if (state != BRLD && br_load)
                    brld_pend <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (br_load)
                            state <= BRLD;
                    end
                    BRLD: begin
                        state <= RUN;
                    end
                    FWAIT: begin
                        if (brld_pend) begin
                            state     <= BRLD;
                            brld_pend <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end

            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (IF_Flush && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       ID_rs = '0, ID_rt = '0, EX_rd = '0;
    logic             ID_uses_rs = 1'b0, ID_uses_rt = 1'b0;
    logic             ID_Branch = 1'b0, ID_BranchTaken = 1'b0;
    logic             EX_MemRead = 1'b0, EX_RegWrite = 1'b0;
    logic             imem_ready = 1'b1;
    logic             PC_Write, IF_ID_Write, IF_Flush, ID_Bubble;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    hazard_stall_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_rd(EX_rd),
        .imem_ready(imem_ready),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .IF_Flush(IF_Flush), .ID_Bubble(ID_Bubble),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] outs;   // {PC_Write, IF_ID_Write, IF_Flush, ID_Bubble}
        logic [3:0] scnt;
        logic [3:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    localparam logic [3:0] RUNO = 4'b1100;
    localparam logic [3:0] STLO = 4'b0001;
    localparam logic [3:0] FLSO = 4'b1110;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] got;
            e   = exp_q.pop_front();
            got = {PC_Write, IF_ID_Write, IF_Flush, ID_Bubble};
            tests++;
            if (got !== e.outs) begin
                failed++;
                $display("FAIL %s outs: got %b required %b", e.name, got, e.outs);
            end
            tests++;
            if (stall_cycles !== e.scnt) begin
                failed++;
                $display("FAIL %s stall_cycles: got %0d required %0d", e.name, stall_cycles, e.scnt);
            end
            tests++;
            if (flush_events !== e.fcnt) begin
                failed++;
                $display("FAIL %s flush_events: got %0d required %0d", e.name, flush_events, e.fcnt);
            end
        end
    end

    // One vector per cycle: apply just after the rising edge, checked at the falling edge
    task automatic step(input string nm, input logic r,
                        input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                        input logic br, input logic bt, input logic mr, input logic rw,
                        input logic [4:0] rd, input logic ir,
                        input logic [3:0] eo, input int es, input int ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        ID_rs = rs; ID_uses_rs = urs; ID_rt = rt; ID_uses_rt = urt;
        ID_Branch = br; ID_BranchTaken = bt;
        EX_MemRead = mr; EX_RegWrite = rw; EX_rd = rd;
        imem_ready = ir;
        e.name = nm; e.outs = eo; e.scnt = 4'(es); e.fcnt = 4'(ef);
        exp_q.push_back(e);
    endtask

    task automatic quiet(input string nm, input logic ir, input logic [3:0] eo, input int es, input int ef);
        step(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, ir, eo, es, ef);
    endtask

    initial begin
        step("reset", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, RUNO, 0, 0);
        quiet("idle", 1'b1, RUNO, 0, 0);

        // load-use
        step("lu_det", 1'b0, 5'd5, 1, 0, 0, 0, 0, 1, 0, 5'd5, 1'b1, STLO, 0, 0);
        quiet("lu_after", 1'b1, RUNO, 1, 0);
        quiet("lu_idle", 1'b1, RUNO, 1, 0);

        // branch after load: detection, BRLD, then taken branch flushes once
        step("bl_det", 1'b0, 0, 0, 5'd7, 1, 1, 0, 1, 0, 5'd7, 1'b1, STLO, 1, 0);
        step("bl_brld", 1'b0, 0, 0, 5'd7, 1, 1, 1, 0, 0, 5'd0, 1'b1, STLO, 2, 0);
        step("bl_taken", 1'b0, 0, 0, 5'd7, 1, 1, 1, 0, 0, 5'd0, 1'b1, FLSO, 3, 0);
        quiet("bl_after", 1'b1, RUNO, 3, 1);

        // branch after ALU op
        step("ba_det", 1'b0, 5'd3, 1, 0, 0, 1, 0, 0, 1, 5'd3, 1'b1, STLO, 3, 1);
        step("ba_resume", 1'b0, 5'd3, 1, 0, 0, 1, 0, 0, 0, 5'd0, 1'b1, RUNO, 4, 1);
        quiet("ba_idle", 1'b1, RUNO, 4, 1);

        // register 0 never hazards
        step("r0_alu", 1'b0, 5'd0, 1, 0, 0, 1, 0, 0, 1, 5'd0, 1'b1, RUNO, 4, 1);
        step("r0_load", 1'b0, 5'd0, 1, 5'd0, 1, 1, 0, 1, 0, 5'd0, 1'b1, RUNO, 4, 1);
        quiet("r0_idle", 1'b1, RUNO, 4, 1);

        // fetch wait starting in br_load cycle
        step("fw_det", 1'b0, 0, 0, 5'd7, 1, 1, 0, 1, 0, 5'd7, 1'b0, STLO, 4, 1);
        quiet("fw_w1", 1'b0, STLO, 5, 1);
        quiet("fw_w2", 1'b0, STLO, 6, 1);
        quiet("fw_ready", 1'b1, RUNO, 7, 1);
        quiet("fw_brld", 1'b1, STLO, 7, 1);
        quiet("fw_run", 1'b1, RUNO, 8, 1);
        quiet("fw_idle", 1'b1, RUNO, 8, 1);

        // plain fetch wait
        quiet("iw_wait", 1'b0, STLO, 8, 1);
        quiet("iw_ready", 1'b1, RUNO, 9, 1);
        quiet("iw_idle", 1'b1, RUNO, 9, 1);

        // taken branch without hazard
        step("tk_taken", 1'b0, 0, 0, 0, 0, 1, 1, 0, 0, 5'd0, 1'b1, FLSO, 9, 1);
        quiet("tk_after", 1'b1, RUNO, 9, 2);

        // reset in the middle of BRLD
        step("rb_det", 1'b0, 0, 0, 5'd7, 1, 1, 0, 1, 0, 5'd7, 1'b1, STLO, 9, 2);
        step("rb_rst", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 1'b1, RUNO, 0, 0);
        quiet("rb_rel", 1'b1, RUNO, 0, 0);
        quiet("rb_idle", 1'b1, RUNO, 0, 0);

        // saturation of stall_cycles
        for (int i = 0; i < 20; i++)
            quiet("sat_wait", 1'b0, STLO, (i > 15) ? 15 : i, 0);
        quiet("sat_ready", 1'b1, RUNO, 15, 0);
        quiet("sat_hold", 1'b1, RUNO, 15, 0);

        // reset clears a pending BRLD
        step("rp_det", 1'b0, 0, 0, 5'd7, 1, 1, 0, 1, 0, 5'd7, 1'b0, STLO, 15, 0);
        step("rp_rst", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 1'b1, RUNO, 0, 0);
        quiet("rp_rel", 1'b1, RUNO, 0, 0);
        quiet("rp_nobrld", 1'b1, RUNO, 0, 0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
